// File: rtl/winograd_tile_scheduler.sv
// Winograd F(2x2,3x3) input-transform tile scheduler: walks a channel in
// overlapping 4x4 tiles (stride 2), fetches each tile from the feature
// buffer, and presents its B^T d B transform with a valid/ready handshake.
//
// winograd_4x4_data_transformation ports:
//   tile_in  : 16 elements, e=i*4+j at [e*DATA_WIDTH +: DATA_WIDTH]
//   tile_out : transformed tile, same packing, wraparound arithmetic
//
// winograd_tile_scheduler ports:
//   clk, rst_n                : clock, async active-low reset
//   start, img_h, img_w,
//   base_addr                 : pass request and its config
//   rd_en, rd_addr, rd_data   : feature-buffer read port (1-cycle latency)
//   tile_valid, tile_ready,
//   tile_data, tile_row,
//   tile_col                  : transformed tile output and its origin
//   busy, done, err           : pass status

module winograd_4x4_data_transformation #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 8
) (
  input  logic [16*DATA_WIDTH-1:0] tile_in,
  output logic [16*DATA_WIDTH-1:0] tile_out
);

  logic [DATA_WIDTH-1:0] d [16];
  logic [DATA_WIDTH-1:0] t [16];
  logic [DATA_WIDTH-1:0] v [16];

  // Only adds and subtracts, so fixed-point scaling is unchanged and
  // FRAC_WIDTH needs no handling here.
  always_comb begin
    for (int e = 0; e < 16; e++) begin
      d[e] = tile_in[e*DATA_WIDTH +: DATA_WIDTH];
    end
    // t = B^T d (row combinations)
    for (int j = 0; j < 4; j++) begin
      t[j]      = d[j]     - d[8+j];
      t[4+j]    = d[4+j]   + d[8+j];
      t[8+j]    = d[8+j]   - d[4+j];
      t[12+j]   = d[4+j]   - d[12+j];
    end
    // v = t B (column combinations)
    for (int i = 0; i < 4; i++) begin
      v[i*4]    = t[i*4]   - t[i*4+2];
      v[i*4+1]  = t[i*4+1] + t[i*4+2];
      v[i*4+2]  = t[i*4+2] - t[i*4+1];
      v[i*4+3]  = t[i*4+1] - t[i*4+3];
    end
    tile_out = '0;
    for (int e = 0; e < 16; e++) begin
      tile_out[e*DATA_WIDTH +: DATA_WIDTH] = v[e];
    end
  end

endmodule

module winograd_tile_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int DIM_WIDTH  = 10,
  parameter int ADDR_WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [DIM_WIDTH-1:0]     img_h,
  input  logic [DIM_WIDTH-1:0]     img_w,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  output logic                     rd_en,
  output logic [ADDR_WIDTH-1:0]    rd_addr,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     tile_valid,
  input  logic                     tile_ready,
  output logic [16*DATA_WIDTH-1:0] tile_data,
  output logic [DIM_WIDTH-1:0]     tile_row,
  output logic [DIM_WIDTH-1:0]     tile_col,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_OUT, S_DONE
  } state_t;

  localparam int XW = DIM_WIDTH + 1;

  state_t state, state_nx;

  logic [DIM_WIDTH-1:0]     h_q, w_q;
  logic [DIM_WIDTH-1:0]     row, col;
  logic [3:0]               k;
  logic [ADDR_WIDTH-1:0]    row_addr;
  logic [ADDR_WIDTH-1:0]    tile_addr;
  logic [ADDR_WIDTH-1:0]    line_addr;
  logic                     err_q;
  logic                     cap_en;
  logic [3:0]               cap_idx;
  logic [16*DATA_WIDTH-1:0] tile;

  logic                     bad_cfg;
  logic                     last_tile;
  logic                     col_wrap;
  logic                     hs;
  logic [ADDR_WIDTH-1:0]    w_ext;
  logic [ADDR_WIDTH-1:0]    next_row_addr;

  assign bad_cfg = (img_h < DIM_WIDTH'(4)) | (img_w < DIM_WIDTH'(4))
                 | img_h[0] | img_w[0];
  assign last_tile = (row == h_q - DIM_WIDTH'(4))
                   & (col == w_q - DIM_WIDTH'(4));
  assign col_wrap = ({1'b0, col} + XW'(2)) > ({1'b0, w_q} - XW'(4));
  assign hs = (state == S_OUT) & tile_ready;
  assign w_ext = ADDR_WIDTH'(w_q);
  assign next_row_addr = row_addr + (w_ext << 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = bad_cfg ? S_DONE : S_FETCH;
      S_FETCH: if (k == 4'd15) state_nx = S_WAIT;
      S_WAIT:  state_nx = S_OUT;
      S_OUT:   if (tile_ready) state_nx = last_tile ? S_DONE : S_FETCH;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en      = 1'b0;
    rd_addr    = '0;
    tile_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    unique case (state)
      S_IDLE:  busy = 1'b0;
      S_FETCH: begin
        rd_en   = 1'b1;
        rd_addr = line_addr + ADDR_WIDTH'(k[1:0]);
      end
      S_WAIT:  ;
      S_OUT:   tile_valid = 1'b1;
      S_DONE:  begin
        done = 1'b1;
        err  = err_q;
      end
      default: busy = 1'b0;
    endcase
  end

  // Tile walk: line_addr points at the current tile row being fetched,
  // tile_addr at the tile origin, row_addr at pixel (row,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q       <= '0;
      w_q       <= '0;
      row       <= '0;
      col       <= '0;
      k         <= '0;
      row_addr  <= '0;
      tile_addr <= '0;
      line_addr <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            h_q       <= img_h;
            w_q       <= img_w;
            err_q     <= bad_cfg;
            row       <= '0;
            col       <= '0;
            k         <= '0;
            row_addr  <= base_addr;
            tile_addr <= base_addr;
            line_addr <= base_addr;
          end
        end
        S_FETCH: begin
          k <= k + 4'd1;
          if (k[1:0] == 2'd3) line_addr <= line_addr + w_ext;
        end
        S_OUT: begin
          if (hs && !last_tile) begin
            if (col_wrap) begin
              row       <= row + DIM_WIDTH'(2);
              col       <= '0;
              row_addr  <= next_row_addr;
              tile_addr <= next_row_addr;
              line_addr <= next_row_addr;
            end else begin
              col       <= col + DIM_WIDTH'(2);
              tile_addr <= tile_addr + ADDR_WIDTH'(2);
              line_addr <= tile_addr + ADDR_WIDTH'(2);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read data arrives one cycle after the strobe; remember which element
  // it belongs to. Reset drops any read still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_en  <= 1'b0;
      cap_idx <= '0;
      tile    <= '0;
    end else begin
      cap_en  <= (state == S_FETCH);
      cap_idx <= k;
      if (cap_en) begin
        tile[int'(cap_idx)*DATA_WIDTH +: DATA_WIDTH] <= rd_data;
      end
    end
  end

  assign tile_row = row;
  assign tile_col = col;

  winograd_4x4_data_transformation #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_WIDTH(FRAC_WIDTH)
  ) u_xform (
    .tile_in (tile),
    .tile_out(tile_data)
  );

endmodule
